score_keeper: RTL and testbench
===============================

// Module: score_keeper
// PURPOSE
//  Upstream feeder of the 8-digit 7-segment multiplexer. Accepts graded step
//  hits from the arrow judge and keeps a 6-digit BCD score and a 2-digit BCD combo.
//  Presents them as a packed 32-bit disp_value, one nibble per display digit.
//  The score is added digit-serially. disp_value updates atomically, so the display never shows a partial sum.
// PARAMETERS
//  PTS_GOOD     24'h000010  BCD points for grade GOOD (must be valid BCD)
//  PTS_GREAT    24'h000020  BCD points for grade GREAT
//  PTS_PERFECT  24'h000050  BCD points for grade PERFECT
//  BONUS_COMBO  8'h10       BCD combo at/above which bonus applies (SCORE_COMBO_BONUS_EN only)
// PORTS
//  CLK         in   1   system clock; all logic on posedge
//  RST         in   1   synchronous, active-high reset
//  clear       in   1   synchronous score/combo clear (new song); 1-cycle pulse
//  hit_valid   in   1   graded hit offered
//  hit_grade   in   2   0=MISS 1=GOOD 2=GREAT 3=PERFECT; sampled with hit_valid&hit_ready
//  hit_ready   out  1   high only in IDLE; hit accepted when hit_valid&hit_ready
//  busy        out  1   high while an addition is in progress
//  disp_value  out  32  [31:24]=combo BCD, [23:0]=score BCD, digit0 = [3:0]
// BEHAVIOUR
//  - Reset (RST=1): disp_value=0, score/combo/work regs=0, state=IDLE, hit_ready=1, busy=0.
//  - Priority: RST > clear > hit. clear zeroes score, combo, and disp_value next cycle.
//    clear aborts any addition in progress and returns the FSM to IDLE. The aborted hit is lost.
//  - FSM states: IDLE -> ADD -> (ADD2 if bonus) -> COMMIT -> IDLE.
//    IDLE: on accept (cycle T), latch points from hit_grade.
//      Combo: next = MISS ? 0 : min(combo+1, 99) in BCD.
//      combo[31:24] of disp_value updates at T+1.
//      MISS (points 0) goes directly to IDLE; the score is unchanged; hit_ready stays 1.
//    ADD: one BCD digit per cycle, digits 0..5, carry held in a flop.
//      Digit sum >9 -> subtract 10, carry=1. Six cycles, T+1..T+6.
//    COMMIT: if carry out of digit 5, score saturates to 24'h999999.
//      Otherwise the working sum is copied to disp_value[23:0] at T+7.
//      Once saturated, the score stays 999999 until clear or RST.
//  - hit_ready=0 and busy=1 from T+1 through COMMIT. An upstream hit held valid is accepted the cycle after COMMIT.
//  - hit_valid in a non-IDLE state is ignored (not accepted); upstream must hold it.
//  - Combo for the bonus test is the pre-increment combo value.
//  - Only BCD digits 0-9 ever appear on disp_value.
// CONFIGURATION
//  SCORE_COMBO_BONUS_EN defined:
//    when the pre-increment combo >= BONUS_COMBO, the points are added twice.
//    The second pass runs in ADD2, six more cycles, so COMMIT is at T+13.
//    Saturation is checked after each pass.
//  Undefined: no ADD2 state; points are added once; BONUS_COMBO is unused.
// STRUCTURE
//  score_pkg:
//    grade enum (G_MISS, G_GOOD, G_GREAT, G_PERFECT) and FSM state enum.
//    Constants BCD_MAX_SCORE=24'h999999 and BCD_MAX_COMBO=8'h99.
//  Sub-module bcd_digit_add: 4b a + 4b b + cin -> 4b sum, cout. Pure combinational.
//    Instantiated once for the serial score path; a second copy is used for the combo increment.
// TESTING
//  1. RST high 2 cycles -> disp_value=0, hit_ready=1, busy=0.
//  2. PERFECT accepted at T from 0 -> combo=8'h01 at T+1;
//     disp_value=32'h01000050 at T+7; hit_ready back to 1 at T+7.
//  3. Score 24'h000095 plus GOOD -> 24'h000105 (digit carry).
//     Score 24'h999990 plus GREAT -> saturates at 24'h999999.
//  4. 99 non-MISS hits -> combo 8'h99. One more GOOD -> combo stays 8'h99.
//     Then MISS -> combo 8'h00, score unchanged, no busy cycle.
//  5. Accept PERFECT, then pulse clear at T+3 -> disp_value=0 at T+4, FSM in IDLE, hit_ready=1.
//  6. (SCORE_COMBO_BONUS_EN) Combo 8'h10 plus GOOD -> score +24'h000020, commit at T+13.
//     Same stimulus without the macro -> +24'h000010, commit at T+7.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the score keeper.
//   grade_e : graded hit from the arrow judge (MISS/GOOD/GREAT/PERFECT)
//   state_e : score FSM states
//   BcdMaxScore / BcdMaxCombo : saturation values in BCD
package score_keeper_pkg;

  typedef enum logic [1:0] {
    GMiss    = 2'd0,
    GGood    = 2'd1,
    GGreat   = 2'd2,
    GPerfect = 2'd3
  } grade_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StAdd2 = 2'd2
  } state_e;

  localparam int unsigned NumScoreDigits = 6;
  localparam logic [23:0] BcdMaxScore    = 24'h999999;
  localparam logic [7:0]  BcdMaxCombo    = 8'h99;

endpackage

// File: rtl/score_keeper_if.sv
// Hit/display bundle between the arrow judge, the score keeper and the display mux.
//   clear      : new-song clear pulse (master -> slave)
//   hit_valid  : graded hit offered (master -> slave)
//   hit_grade  : 0=MISS 1=GOOD 2=GREAT 3=PERFECT (master -> slave)
//   hit_ready  : keeper can accept a hit (slave -> master)
//   busy       : score addition in progress (slave -> master)
//   disp_value : {combo[7:0], score[23:0]} BCD, digit0 in [3:0] (slave -> master)
interface score_keeper_if;
  logic        clear;
  logic        hit_valid;
  logic [1:0]  hit_grade;
  logic        hit_ready;
  logic        busy;
  logic [31:0] disp_value;

  modport master (
    output clear, hit_valid, hit_grade,
    input  hit_ready, busy, disp_value
  );

  modport slave (
    input  clear, hit_valid, hit_grade,
    output hit_ready, busy, disp_value
  );
endinterface

// File: rtl/score_keeper_bcd_digit_add.sv
// One-digit BCD adder: a_i + b_i + cin_i -> sum_o (0-9), cout_o. Purely combinational.
//   a_i, b_i : BCD digits (0-9)
//   cin_i    : carry in
//   sum_o    : BCD sum digit
//   cout_o   : decimal carry out
module score_keeper_bcd_digit_add (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  logic [4:0] raw;

  assign raw    = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
  assign cout_o = (raw > 5'd9);
  assign sum_o  = cout_o ? 4'(raw - 5'd10) : raw[3:0];
endmodule

// File: rtl/score_keeper.sv
// Score keeper feeding the 8-digit 7-segment multiplexer.
// Accepts graded hits, keeps a 6-digit BCD score and a 2-digit BCD combo, and presents them
// as disp_value = {combo, score}. The score is added one BCD digit per cycle into a working
// register; disp_value only changes when a full (possibly saturated) sum is committed.
// Ports:
//   CLK  : clock, all logic on posedge
//   RST  : synchronous active-high reset
//   bus  : score_keeper_if.slave (clear, hit_valid/hit_grade/hit_ready, busy, disp_value)
// Build option: define SCORE_COMBO_BONUS_EN to add the points twice (second pass in StAdd2)
// when the pre-increment combo is at or above BONUS_COMBO.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter logic [23:0] PTS_GOOD    = 24'h000010,
  parameter logic [23:0] PTS_GREAT   = 24'h000020,
  parameter logic [23:0] PTS_PERFECT = 24'h000050,
  parameter logic [7:0]  BONUS_COMBO = 8'h10
) (
  input logic           CLK,
  input logic           RST,
  score_keeper_if.slave bus
);

  state_e      state_q, state_d;
  logic [23:0] score_q, score_d;
  logic [7:0]  combo_q, combo_d;
  logic [23:0] work_q,  work_d;
  logic [23:0] pts_q,   pts_d;
  logic [2:0]  digit_q, digit_d;
  logic        carry_q, carry_d;
`ifdef SCORE_COMBO_BONUS_EN
  logic        bonus_q, bonus_d;
`else
  logic        unused_bonus_combo;
  assign unused_bonus_combo = ^BONUS_COMBO;
`endif

  logic        accept;
  logic [23:0] hit_pts;
  logic [4:0]  nib_lsb;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cout;
  logic        last_digit;
  logic [23:0] pass_sum, pass_result;
  logic [3:0]  cinc_lo, cinc_hi;
  logic        cinc_lo_cout, unused_cinc_hi_cout;
  logic [7:0]  combo_inc;

  assign accept     = (state_q == StIdle) && bus.hit_valid;
  assign last_digit = (digit_q == 3'(NumScoreDigits - 1));

  always_comb begin
    hit_pts = '0;
    unique case (grade_e'(bus.hit_grade))
      GMiss:    hit_pts = '0;
      GGood:    hit_pts = PTS_GOOD;
      GGreat:   hit_pts = PTS_GREAT;
      GPerfect: hit_pts = PTS_PERFECT;
      default:  hit_pts = '0;
    endcase
  end

  // Serial score path: digit digit_q of work + pts + held carry.
  assign nib_lsb = {digit_q, 2'b00};
  assign add_a   = work_q[nib_lsb +: 4];
  assign add_b   = pts_q[nib_lsb +: 4];

  score_keeper_bcd_digit_add u_score_add (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    pass_sum                 = work_q;
    pass_sum[nib_lsb +: 4]   = add_sum;
  end

  // Carry out of the top digit means the true sum exceeds 999999.
  assign pass_result = add_cout ? BcdMaxScore : pass_sum;

  // Combo increment: +1 into the low digit, ripple into the high digit.
  score_keeper_bcd_digit_add u_combo_lo (
    .a_i    (combo_q[3:0]),
    .b_i    (4'd0),
    .cin_i  (1'b1),
    .sum_o  (cinc_lo),
    .cout_o (cinc_lo_cout)
  );

  score_keeper_bcd_digit_add u_combo_hi (
    .a_i    (combo_q[7:4]),
    .b_i    (4'd0),
    .cin_i  (cinc_lo_cout),
    .sum_o  (cinc_hi),
    .cout_o (unused_cinc_hi_cout)
  );

  assign combo_inc = {cinc_hi, cinc_lo};

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    combo_d = combo_q;
    work_d  = work_q;
    pts_d   = pts_q;
    digit_d = digit_q;
    carry_d = carry_q;
`ifdef SCORE_COMBO_BONUS_EN
    bonus_d = bonus_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (grade_e'(bus.hit_grade) == GMiss) begin
            combo_d = '0;
          end else begin
            combo_d = (combo_q == BcdMaxCombo) ? combo_q : combo_inc;
            work_d  = score_q;
            pts_d   = hit_pts;
            digit_d = '0;
            carry_d = 1'b0;
`ifdef SCORE_COMBO_BONUS_EN
            // Bonus is judged on the combo before this hit counts.
            bonus_d = (combo_q >= BONUS_COMBO);
`endif
            state_d = StAdd;
          end
        end
      end

      StAdd, StAdd2: begin
        work_d  = pass_sum;
        carry_d = add_cout;
        digit_d = digit_q + 3'd1;
        // The commit happens on the edge that closes the last digit, so the new score and
        // hit_ready=1 both appear in the following cycle.
        if (last_digit) begin
          digit_d = '0;
          carry_d = 1'b0;
`ifdef SCORE_COMBO_BONUS_EN
          if ((state_q == StAdd) && bonus_q) begin
            work_d  = pass_result;
            state_d = StAdd2;
          end else begin
            score_d = pass_result;
            state_d = StIdle;
          end
`else
          score_d = pass_result;
          state_d = StIdle;
`endif
        end
      end

      default: state_d = StIdle;
    endcase

    // Clear beats everything except reset and drops any addition in flight.
    if (bus.clear) begin
      state_d = StIdle;
      score_d = '0;
      combo_d = '0;
      work_d  = '0;
      pts_d   = '0;
      digit_d = '0;
      carry_d = 1'b0;
`ifdef SCORE_COMBO_BONUS_EN
      bonus_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      score_q <= '0;
      combo_q <= '0;
      work_q  <= '0;
      pts_q   <= '0;
      digit_q <= '0;
      carry_q <= 1'b0;
`ifdef SCORE_COMBO_BONUS_EN
      bonus_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      combo_q <= combo_d;
      work_q  <= work_d;
      pts_q   <= pts_d;
      digit_q <= digit_d;
      carry_q <= carry_d;
`ifdef SCORE_COMBO_BONUS_EN
      bonus_q <= bonus_d;
`endif
    end
  end

  assign bus.hit_ready  = (state_q == StIdle);
  assign bus.busy       = (state_q != StIdle);
  assign bus.disp_value = {combo_q, score_q};

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: two instances share one stimulus stream. u_dut0 uses the default
// points; u_dut1 uses larger points so carries and saturation are reached quickly.
// A decimal model (integers, min(), digit conversion) predicts disp_value/hit_ready/busy
// every cycle; directed sections add hand-computed literal expectations.
module tb_score_keeper;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  score_keeper_if bus0 ();
  score_keeper_if bus1 ();

  assign bus1.clear     = bus0.clear;
  assign bus1.hit_valid = bus0.hit_valid;
  assign bus1.hit_grade = bus0.hit_grade;

  score_keeper u_dut0 (
    .CLK (clk),
    .RST (rst),
    .bus (bus0)
  );

  score_keeper #(
    .PTS_GOOD    (24'h000095),
    .PTS_GREAT   (24'h000010),
    .PTS_PERFECT (24'h333333)
  ) u_dut1 (
    .CLK (clk),
    .RST (rst),
    .bus (bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_live = 1'b0;
  int m_score[2];
  int m_pend[2];
  int m_combo;
  int m_remain;

  function automatic int pts_of(input int inst, input int g);
    case (g)
      1:       return (inst == 0) ? 10 : 95;
      2:       return (inst == 0) ? 20 : 10;
      3:       return (inst == 0) ? 50 : 333333;
      default: return 0;
    endcase
  endfunction

  function automatic logic [23:0] to_bcd6(input int v);
    logic [23:0] r;
    int t;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] to_bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_live = 1'b1;
        m_combo = 0;
        m_remain = 0;
        for (int i = 0; i < 2; i++) begin
          m_score[i] = 0;
          m_pend[i]  = 0;
        end
      end else if (bus0.clear) begin
        m_combo = 0;
        m_remain = 0;
        for (int i = 0; i < 2; i++) m_score[i] = 0;
      end else if (m_remain > 0) begin
        m_remain--;
        if (m_remain == 0) for (int i = 0; i < 2; i++) m_score[i] = m_pend[i];
      end else if (bus0.hit_valid) begin
        int g;
        int mult;
        g = int'(bus0.hit_grade);
        mult = 1;
`ifdef SCORE_COMBO_BONUS_EN
        if (m_combo >= 10) mult = 2;
`endif
        if (g == 0) begin
          m_combo = 0;
        end else begin
          if (m_combo < 99) m_combo++;
          for (int i = 0; i < 2; i++) begin
            m_pend[i] = m_score[i] + mult * pts_of(i, g);
            if (m_pend[i] > 999999) m_pend[i] = 999999;
          end
          m_remain = 6 * mult;
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        check("model_disp0", bus0.disp_value, {to_bcd2(m_combo), to_bcd6(m_score[0])});
        check("model_disp1", bus1.disp_value, {to_bcd2(m_combo), to_bcd6(m_score[1])});
        check("model_ready", {31'd0, bus0.hit_ready}, {31'd0, m_remain == 0});
        check("model_busy",  {31'd0, bus0.busy},      {31'd0, m_remain != 0});
        check("ready_match", {31'd0, bus1.hit_ready}, {31'd0, bus0.hit_ready});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // Returns at the drive point of cycle T+1 (T = accept cycle).
  task automatic send(input logic [1:0] g);
    int k;
    bus0.hit_valid = 1'b1;
    bus0.hit_grade = g;
    k = 0;
    @(negedge clk);
    while (!bus0.hit_ready && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (!bus0.hit_ready) check("accept_timeout", 32'd0, 32'd1);
    to_drive();
    bus0.hit_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (!bus0.hit_ready && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (!bus0.hit_ready) check("idle_timeout", 32'd0, 32'd1);
    to_drive();
  endtask

  task automatic pulse_clear();
    bus0.clear = 1'b1;
    to_drive();
    bus0.clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus0.clear = 1'b0;
    bus0.hit_valid = 1'b0;
    bus0.hit_grade = 2'd0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_disp",  bus0.disp_value, 32'h0);
    check("rst_ready", {31'd0, bus0.hit_ready}, 32'd1);
    check("rst_busy",  {31'd0, bus0.busy}, 32'd0);
    to_drive();
    rst = 1'b0;

    // PERFECT from zero: combo at T+1, score at T+7.
    send(2'd3);
    @(negedge clk);
    check("t2_combo_t1", bus0.disp_value, 32'h01000000);
    check("t2_busy_t1",  {31'd0, bus0.busy}, 32'd1);
    check("t2_ready_t1", {31'd0, bus0.hit_ready}, 32'd0);
    repeat (5) @(negedge clk);
    check("t2_hold_t6", bus0.disp_value, 32'h01000000);
    @(negedge clk);
    check("t2_disp_t7",  bus0.disp_value, 32'h01000050);
    check("t2_disp1_t7", bus1.disp_value, 32'h01333333);
    check("t2_ready_t7", {31'd0, bus0.hit_ready}, 32'd1);
    to_drive();

    // Digit carry 050+050 -> 100.
    send(2'd3);
    wait_idle();
    @(negedge clk);
    check("t3_carry", bus0.disp_value, 32'h02000100);
    to_drive();

    pulse_clear();
    @(negedge clk);
    check("clr_disp0", bus0.disp_value, 32'h0);
    check("clr_disp1", bus1.disp_value, 32'h0);
    to_drive();

    // 95 + 10 -> 105 on u_dut1; 10 + 20 -> 30 on u_dut0.
    send(2'd1);
    wait_idle();
    send(2'd2);
    wait_idle();
    @(negedge clk);
    check("t3_chain1", bus1.disp_value, 32'h02000105);
    check("t3_chain0", bus0.disp_value, 32'h02000030);
    to_drive();

    // Saturation on u_dut1 and it sticks.
    repeat (3) begin
      send(2'd3);
      wait_idle();
    end
    @(negedge clk);
    check("t3_sat", bus1.disp_value, 32'h05999999);
    to_drive();
    send(2'd2);
    wait_idle();
    @(negedge clk);
    check("t3_sat_hold", bus1.disp_value, 32'h06999999);
    check("t3_dut0",     bus0.disp_value, 32'h06000200);
    to_drive();

    // Clear during an addition.
    pulse_clear();
    send(2'd3);          // now in T+1
    to_drive();          // T+2
    to_drive();          // T+3
    bus0.clear = 1'b1;
    to_drive();          // T+4
    bus0.clear = 1'b0;
    @(negedge clk);
    check("t5_disp",  bus0.disp_value, 32'h0);
    check("t5_ready", {31'd0, bus0.hit_ready}, 32'd1);
    check("t5_busy",  {31'd0, bus0.busy}, 32'd0);
    repeat (8) @(negedge clk);
    check("t5_lost", bus0.disp_value, 32'h0);
    to_drive();

    // Combo saturation at 99, then MISS.
    repeat (99) begin
      send(2'd1);
      wait_idle();
    end
    @(negedge clk);
    check("t4_combo99", {24'd0, bus0.disp_value[31:24]}, 32'h99);
    to_drive();
    send(2'd1);
    wait_idle();
    @(negedge clk);
    check("t4_combo_hold", {24'd0, bus0.disp_value[31:24]}, 32'h99);
    to_drive();
    send(2'd0);
    @(negedge clk);
`ifdef SCORE_COMBO_BONUS_EN
    check("t4_miss", bus0.disp_value, 32'h00001900);
`else
    check("t4_miss", bus0.disp_value, 32'h00001000);
`endif
    check("t4_miss_busy",  {31'd0, bus0.busy}, 32'd0);
    check("t4_miss_ready", {31'd0, bus0.hit_ready}, 32'd1);
    to_drive();

    // Bonus threshold: 10 GOODs, then GOOD at combo 10.
    pulse_clear();
    repeat (10) begin
      send(2'd1);
      wait_idle();
    end
    send(2'd1);
    repeat (6) @(negedge clk);
    check("t6_before", bus0.disp_value, 32'h11000100);
    @(negedge clk);
`ifdef SCORE_COMBO_BONUS_EN
    check("t6_t7", bus0.disp_value, 32'h11000100);
    repeat (6) @(negedge clk);
    check("t6_t13", bus0.disp_value, 32'h11000120);
`else
    check("t6_t7", bus0.disp_value, 32'h11000110);
`endif
    to_drive();

    // Random traffic, including hits held through busy and occasional clears.
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      bus0.clear     = (r < 2);
      bus0.hit_valid = (r >= 2) && (r < 62);
      bus0.hit_grade = 2'($urandom_range(0, 3));
      to_drive();
    end
    bus0.clear = 1'b0;
    bus0.hit_valid = 1'b0;
    repeat (20) to_drive();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
